// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_ctrl_pkg
//  Description : Shared types and constants for the pipeline hazard/stall
//                sequencer: sequencer state encoding, zero-register id and
//                performance counter width.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        MEM_DONE = 2'd2
    } ctrl_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam int         PERF_W   = 32;

    // True when a source register id names the given destination register.
    function automatic logic src_matches(input logic [4:0] rd, input logic [4:0] rs);
        return (rd == rs);
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_use_detect.sv
`default_nettype none
// ============================================================================
//  Module      : load_use_detect
//  Description : Purely combinational load-use hazard compare between the
//                load in EX and the source operands of the instruction in ID.
//                Loads targeting x0 never create a dependency.
//  Revision    : 1.0 - initial release
// ============================================================================
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic       memread,
    input  logic [4:0] rd,
    input  logic [4:0] rs1,
    input  logic [4:0] rs2,
    output logic       hazard
);

    // Hazard when a real destination register of a load feeds either ID source.
    always_comb begin
        hazard = memread && (rd != REG_ZERO) &&
                 (src_matches(rd, rs1) || src_matches(rd, rs2));
    end

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_hazard_ctrl
//  Description : Central stall/flush sequencer for the 5-stage pipeline.
//                Freezes the pipeline while a data-cache miss is outstanding
//                (with timeout abort), inserts load-use bubbles and issues
//                branch flushes of IF/ID. Priority: stall > bubble > flush.
//                Build option PIPE_PERF_CNT_EN enables the three 32-bit perf
//                counters; otherwise those ports are tied to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 256,
    parameter int TO_W        = 9
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              id_ex_memread_i,
    input  logic [4:0]        id_ex_rd_i,
    input  logic [4:0]        if_id_rs1_i,
    input  logic [4:0]        if_id_rs2_i,
    input  logic              branch_taken_i,
    input  logic              mem_req_i,
    input  logic              dcache_hit_i,
    input  logic              dcache_ack_i,
    output logic              pc_write_o,
    output logic              if_id_write_o,
    output logic              if_id_flush_o,
    output logic              id_ex_bubble_o,
    output logic              cpu_stall_o,
    output logic              err_timeout_o,
    output logic [PERF_W-1:0] stall_cyc_o,
    output logic [PERF_W-1:0] bubble_cnt_o,
    output logic [PERF_W-1:0] flush_cnt_o
);

    // Last wait-count value before the miss is abandoned.
    localparam logic [TO_W-1:0] C_TO_LAST = TO_W'(MEM_TIMEOUT - 1);

    ctrl_state_t     r_state;
    ctrl_state_t     w_state_next;
    logic [TO_W-1:0] r_to_cnt;
    logic [TO_W-1:0] w_to_cnt_next;
    logic            r_err;
    logic            w_err_set;
    logic            w_fsm_stall;
    logic            w_miss;
    logic            w_hazard;

    assign w_miss = mem_req_i & ~dcache_hit_i;

    load_use_detect u_load_use (
        .memread (id_ex_memread_i),
        .rd      (id_ex_rd_i),
        .rs1     (if_id_rs1_i),
        .rs2     (if_id_rs2_i),
        .hazard  (w_hazard)
    );

    // Sequencer state, wait counter and sticky timeout flag.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state  <= RUN;
            r_to_cnt <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_to_cnt <= w_to_cnt_next;
            r_err    <= r_err | w_err_set;
        end
    end

    // Miss sequencing: a miss stalls in the same cycle it is seen; the fill
    // cycle after ack never stalls because the fill data is forwarded.
    always_comb begin
        w_state_next  = r_state;
        w_to_cnt_next = r_to_cnt;
        w_err_set     = 1'b0;
        w_fsm_stall   = 1'b0;
        case (r_state)
            RUN: begin
                if (w_miss) begin
                    w_fsm_stall   = 1'b1;
                    w_state_next  = MEM_WAIT;
                    w_to_cnt_next = '0;
                end
            end
            MEM_WAIT: begin
                w_fsm_stall   = 1'b1;
                w_to_cnt_next = r_to_cnt + TO_W'(1);
                if (dcache_ack_i) begin
                    w_state_next = MEM_DONE;
                end else if (r_to_cnt == C_TO_LAST) begin
                    w_err_set    = 1'b1;
                    w_state_next = RUN;
                end
            end
            MEM_DONE: begin
                w_state_next = RUN;
            end
            default: begin
                w_state_next = RUN;
            end
        endcase
    end

    // Pipeline controls by priority; reset forces the idle pattern so no
    // stale stall reaches the pipeline registers while they are held.
    always_comb begin
        pc_write_o     = 1'b1;
        if_id_write_o  = 1'b1;
        if_id_flush_o  = 1'b0;
        id_ex_bubble_o = 1'b0;
        cpu_stall_o    = 1'b0;
        if (rst_n_i) begin
            if (w_fsm_stall) begin
                cpu_stall_o   = 1'b1;
                pc_write_o    = 1'b0;
                if_id_write_o = 1'b0;
            end else if (w_hazard) begin
                id_ex_bubble_o = 1'b1;
                pc_write_o     = 1'b0;
                if_id_write_o  = 1'b0;
            end else if (branch_taken_i) begin
                if_id_flush_o = 1'b1;
            end
        end
    end

    assign err_timeout_o = r_err;

`ifdef PIPE_PERF_CNT_EN
    logic [PERF_W-1:0] r_stall_cyc;
    logic [PERF_W-1:0] r_bubble_cnt;
    logic [PERF_W-1:0] r_flush_cnt;

    // Event counters, wrapping, bumped on each cycle the event output is high.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_stall_cyc  <= '0;
            r_bubble_cnt <= '0;
            r_flush_cnt  <= '0;
        end else begin
            if (cpu_stall_o) begin
                r_stall_cyc <= r_stall_cyc + PERF_W'(1);
            end
            if (id_ex_bubble_o) begin
                r_bubble_cnt <= r_bubble_cnt + PERF_W'(1);
            end
            if (if_id_flush_o) begin
                r_flush_cnt <= r_flush_cnt + PERF_W'(1);
            end
        end
    end

    assign stall_cyc_o  = r_stall_cyc;
    assign bubble_cnt_o = r_bubble_cnt;
    assign flush_cnt_o  = r_flush_cnt;
`else
    assign stall_cyc_o  = '0;
    assign bubble_cnt_o = '0;
    assign flush_cnt_o  = '0;
`endif

endmodule
`default_nettype wire
